tdm_demux8: RTL and testbench
=============================

Name: tdm_demux8

Overview:
- Receive-side counterpart of the 8:1 nibble mux. Accepts a time-division stream of WIDTH-bit beats, one beat per slot, frame-aligned by a start-of-frame marker.
- Distributes the 8 slots onto 8 parallel registered outputs A..H.
- Outputs are double-buffered: A..H change only when a complete, error-free frame has been received. A one-cycle frame_valid strobe marks each update.
- Sits after the mux/serial link and feeds parallel consumers.

Parameters:
- WIDTH, 4: bit width of each beat and of each output A..H.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  beat data.
- din_valid  input  1  din is valid this cycle. A beat is accepted on every cycle din_valid=1; there is no backpressure.
- sof  input  1  start of frame. Meaningful only when din_valid=1; marks that beat as slot 0.
- A  output  WIDTH  slot 0 of the last complete frame.
- B  output  WIDTH  slot 1 of the last complete frame.
- C  output  WIDTH  slot 2 of the last complete frame.
- D  output  WIDTH  slot 3 of the last complete frame.
- E  output  WIDTH  slot 4 of the last complete frame.
- F  output  WIDTH  slot 5 of the last complete frame.
- G  output  WIDTH  slot 6 of the last complete frame.
- H  output  WIDTH  slot 7 of the last complete frame.
- slot  output  3  index of the next slot expected in the current frame; 0 when IDLE.
- busy  output  1  1 while in RECV.
- frame_valid  output  1  one-cycle pulse: A..H were just updated with a new frame.
- frame_err  output  1  one-cycle pulse: a frame was aborted by an early sof.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Synchronous, active-high reset.
  - rst=1 at a rising edge forces: state=IDLE, slot=0, busy=0, A..H=0, all 8 shadow registers=0, frame_valid=0, frame_err=0.
  - rst has priority over every other input. Asserting it mid-frame discards the partial frame with no frame_err.
- Internal storage: shadow[0..7], each WIDTH bits, plus a 3-bit slot counter.
- States: IDLE, RECV.
- IDLE:
  - din_valid=1, sof=1: shadow[0]<=din, slot<=1, go to RECV.
  - din_valid=1, sof=0: beat dropped, no flag raised, stay in IDLE.
  - din_valid=0: nothing happens; sof is ignored.
- RECV, din_valid=0: hold all state. Gaps between beats are unbounded, with no timeout.
- RECV, din_valid=1, sof=0, slot<7: shadow[slot]<=din, slot<=slot+1.
- RECV, din_valid=1, sof=0, slot==7 (last beat):
  - A..G<=shadow[0..6] and H<=din, all in the same edge.
  - frame_valid<=1 for exactly one cycle.
  - slot<=0, go to IDLE.
  - Latency: outputs and frame_valid become visible in the cycle after the 8th beat is accepted.
- RECV, din_valid=1, sof=1 (early restart):
  - frame_err<=1 for one cycle.
  - Partial frame discarded; A..H unchanged.
  - The beat is taken as slot 0 of a new frame: shadow[0]<=din, slot<=1, stay in RECV.
- Back-to-back frames: a sof beat in the cycle immediately after a last beat is accepted (state is IDLE), so full-rate streaming with zero idle cycles is supported.
- Outputs A..H hold their value between frame_valid pulses. There is no partial update.
- frame_valid and frame_err are mutually exclusive and never high together.
- Slot counter: 3 bits, wraps 7->0 only via frame completion, never by overflow arithmetic.
- busy = (state==RECV). It is registered, consistent with state.

Test Plan:
- Reset: rst=1 for 2 cycles with din_valid toggling -> A..H=0, slot=0, busy=0, frame_valid=0, frame_err=0.
- Nominal frame: sof+din=1, then din=2..8 on 7 consecutive cycles -> next cycle A=1, B=2, C=3, D=4, E=5, F=6, G=7, H=8, frame_valid=1 for one cycle, slot=0.
- Gapped frame: same data as the nominal frame, with din_valid=0 for 3 cycles between beats 3 and 4 -> identical A..H. frame_valid fires only after the 8th beat; A..H do not change during the gap.
- Early sof: 5 beats (values 9..13), then sof with din=4'hF followed by 7 beats 1..7 -> frame_err pulses when the second sof is accepted; A..H keep the prior frame until completion, then A=F, B..H=1..7.
- Stray beats and back-to-back: 3 beats without sof in IDLE are ignored, with no flags. Then two sof frames with no idle cycle between them (0..7 then 7..0) -> two frame_valid pulses 8 cycles apart; final A=7 ... H=0.
- Mid-frame reset: rst=1 after 4 beats, then a full frame 1..8 -> no frame_err and no frame_valid from the aborted frame; after reset A..H=0, then A..H=1..8 on completion.

Source files
------------

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive-side slot demultiplexer for an 8-slot TDM beat stream.
// Beats are collected into shadow registers; A..H are refreshed together only
// when all 8 slots of a frame arrive without an intervening start-of-frame.
module tdm_demux8 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [2:0]       slot,
  output logic             busy,
  output logic             frame_valid,
  output logic             frame_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow_q [8];
  logic [WIDTH-1:0] shadow_d [8];
  logic [WIDTH-1:0] out_q [8];
  logic [WIDTH-1:0] out_d [8];
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;

  // Next-state logic: frame assembly, commit on the 8th beat, restart on early sof.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (din_valid && sof) begin
          shadow_d[0] = din;
          slot_d      = 3'd1;
          state_d     = RECV;
        end
      end
      RECV: begin
        if (din_valid) begin
          if (sof) begin
            frame_err_d = 1'b1;
            shadow_d[0] = din;
            slot_d      = 3'd1;
          end else if (slot_q == 3'd7) begin
            for (int i = 0; i < 7; i++) begin
              out_d[i] = shadow_q[i];
            end
            out_d[7]      = din;
            frame_valid_d = 1'b1;
            slot_d        = 3'd0;
            state_d       = IDLE;
          end else begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = 3'd0;
      end
    endcase
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= 3'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
        out_q[i]    <= out_d[i];
      end
    end
  end

  assign A           = out_q[0];
  assign B           = out_q[1];
  assign C           = out_q[2];
  assign D           = out_q[3];
  assign E           = out_q[4];
  assign F           = out_q[5];
  assign G           = out_q[6];
  assign H           = out_q[7];
  assign slot        = slot_q;
  assign busy        = (state_q == RECV);
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed test-plan sequences followed by random traffic,
// every cycle compared against a frame-level reference model.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       sof = 1'b0;
  logic [3:0] A, B, C, D, E, F, G, H;
  logic [2:0] slot;
  logic       busy, frame_valid, frame_err;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: the frame being collected as a list of beats.
  logic [3:0] frame_q [$];
  bit         in_frame = 1'b0;
  logic [3:0] exp_out [8];
  bit         exp_fv = 1'b0;
  bit         exp_fe = 1'b0;
  int         fv_cycles [$];
  int         cycle = 0;

  tdm_demux8 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .slot(slot), .busy(busy), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
  endtask

  // Advance the model by one accepted clock edge.
  task automatic modelEdge(input logic r, input logic v, input logic s, input logic [3:0] d);
    exp_fv = 1'b0;
    exp_fe = 1'b0;
    if (r) begin
      frame_q.delete();
      in_frame = 1'b0;
      for (int i = 0; i < 8; i++) exp_out[i] = '0;
    end else if (v) begin
      if (s) begin
        exp_fe = in_frame;
        frame_q.delete();
        frame_q.push_back(d);
        in_frame = 1'b1;
      end else if (in_frame) begin
        frame_q.push_back(d);
        if (frame_q.size() == 8) begin
          for (int i = 0; i < 8; i++) exp_out[i] = frame_q[i];
          exp_fv = 1'b1;
          frame_q.delete();
          in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("A", A, exp_out[0]);
    check("B", B, exp_out[1]);
    check("C", C, exp_out[2]);
    check("D", D, exp_out[3]);
    check("E", E, exp_out[4]);
    check("F", F, exp_out[5]);
    check("G", G, exp_out[6]);
    check("H", H, exp_out[7]);
    check("slot", slot, in_frame ? frame_q.size() : 0);
    check("busy", busy, in_frame);
    check("frame_valid", frame_valid, exp_fv);
    check("frame_err", frame_err, exp_fe);
    if (frame_valid) fv_cycles.push_back(cycle);
  endtask

  // Drive one cycle of inputs, clock it, then compare 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic s, input logic [3:0] d);
    rst = r; din_valid = v; sof = s; din = d;
    @(posedge clk);
    cycle++;
    modelEdge(r, v, s, d);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    logic [3:0] v;
    int gap_fv;

    // Reset with din_valid toggling.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h5);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hA);
    check("reset_A", A, 4'h0);
    check("reset_slot", slot, 3'd0);
    idle(2);

    // Nominal frame 1..8.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, (i == 0), 4'(i + 1));
    check("nominal_fv", frame_valid, 1'b1);
    check("nominal_A", A, 4'h1);
    check("nominal_H", H, 4'h8);
    idle(1);
    check("nominal_fv_one_cycle", frame_valid, 1'b0);

    // Gapped frame: 3 idle cycles between beats 3 and 4.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) idle(3);
      applyStimulus(1'b0, 1'b1, (i == 0), 4'(i + 1));
    end
    check("gapped_fv", frame_valid, 1'b1);
    check("gapped_E", E, 4'h5);
    idle(2);

    // Early sof: 5 beats 9..13, then sof with F and 7 beats 1..7.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, (i == 0), 4'(9 + i));
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
    check("early_err", frame_err, 1'b1);
    check("early_A_held", A, 4'h1);
    for (int i = 1; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'(i));
    check("early_A", A, 4'hF);
    check("early_H", H, 4'h7);
    idle(2);

    // Stray beats, then two back-to-back frames.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'hC);
    check("stray_busy", busy, 1'b0);
    fv_cycles.delete();
    for (int i = 0; i < 16; i++) begin
      v = (i < 8) ? 4'(i) : 4'(15 - i);
      applyStimulus(1'b0, 1'b1, (i % 8 == 0), v);
    end
    check("b2b_pulses", fv_cycles.size(), 2);
    gap_fv = (fv_cycles.size() == 2) ? fv_cycles[1] - fv_cycles[0] : -1;
    check("b2b_spacing", gap_fv, 8);
    check("b2b_A", A, 4'h7);
    check("b2b_H", H, 4'h0);

    // Mid-frame reset, then a full frame.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, (i == 0), 4'(i + 3));
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    check("midrst_A", A, 4'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, (i == 0), 4'(i + 1));
    check("midrst_G", G, 4'h7);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(9) < 7),
                    ($urandom_range(11) == 0), 4'($urandom));
    end
    idle(2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
